// File: rtl/router_req_sched_if.sv
// -----------------------------------------------------------------------------
// router_req_sched_if
// Start/ack handshake between the request scheduler and the router.
//   router_start_req  scheduler -> router  level request, held until ack
//   router_scr_addr   scheduler -> router  source address of the issued request
//   router_dst_addr   scheduler -> router  destination address
//   router_src_dfx    scheduler -> router  source DFX region id
//   router_dst_dfx    scheduler -> router  destination DFX region id
//   router_ack        router -> scheduler  router accepted the current request
// Modports: master = scheduler side, slave = router side.
// -----------------------------------------------------------------------------
interface router_req_sched_if #(
  parameter int ADDR_W = 10,
  parameter int DFX_W  = 2
);
  logic              router_start_req;
  logic [ADDR_W-1:0] router_scr_addr;
  logic [ADDR_W-1:0] router_dst_addr;
  logic [DFX_W-1:0]  router_src_dfx;
  logic [DFX_W-1:0]  router_dst_dfx;
  logic              router_ack;

  modport master (
    output router_start_req,
    output router_scr_addr,
    output router_dst_addr,
    output router_src_dfx,
    output router_dst_dfx,
    input  router_ack
  );

  modport slave (
    input  router_start_req,
    input  router_scr_addr,
    input  router_dst_addr,
    input  router_src_dfx,
    input  router_dst_dfx,
    output router_ack
  );
endinterface

// File: rtl/router_req_sched.sv
// -----------------------------------------------------------------------------
// router_req_sched
// Multi-channel request scheduler in front of the router start/ack handshake.
// Each channel queues route requests in its own FIFO; a round-robin arbiter
// issues one request at a time to the router and holds it until acknowledged.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   ch_req_valid    per-channel push strobe
//   ch_req_ready    per-channel "FIFO not full" (registered)
//   ch_src_addr     packed per-channel source address, ch i at [i*ADDR_W +: ADDR_W]
//   ch_dst_addr     packed per-channel destination address
//   ch_src_dfx      packed per-channel source DFX id, ch i at [i*DFX_W +: DFX_W]
//   ch_dst_dfx      packed per-channel destination DFX id
//   rtr             router handshake (router_req_sched_if.master)
//   grant_ch        channel of the in-flight request (holds last value in IDLE)
//   busy            request outstanding at the router
//   ch_done         one-cycle pulse on the granted channel's bit when acked
//   timeout_err     one-cycle pulse when a request is aborted by timeout
//
// Build option
//   ROUTER_REQ_TIMEOUT_EN  when defined, a request not acked within
//                          TIMEOUT_CYCLES cycles is dropped and timeout_err
//                          pulses; otherwise the request waits indefinitely
//                          and timeout_err is tied low.
// -----------------------------------------------------------------------------
module router_req_sched #(
  parameter int NUM_CH         = 4,
  parameter int ADDR_W         = 10,
  parameter int DFX_W          = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_req_valid,
  output logic [NUM_CH-1:0]        ch_req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] ch_src_addr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_dst_addr,
  input  logic [NUM_CH*DFX_W-1:0]  ch_src_dfx,
  input  logic [NUM_CH*DFX_W-1:0]  ch_dst_dfx,
  router_req_sched_if.master       rtr,
  output logic [CH_W-1:0]          grant_ch,
  output logic                     busy,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     timeout_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [DFX_W-1:0]  src_dfx;
    logic [DFX_W-1:0]  dst_dfx;
  } req_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Per-channel FIFO storage and bookkeeping
  req_t             fifo_mem [NUM_CH][FIFO_DEPTH];
  req_t             wr_ent   [NUM_CH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0] wr_ptr_d [NUM_CH];
  logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0] rd_ptr_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q    [NUM_CH];
  logic [CNT_W-1:0] cnt_d    [NUM_CH];
  logic [NUM_CH-1:0] ready_q, ready_d;
  logic [NUM_CH-1:0] push, pop;

  // Arbiter
  logic [NUM_CH-1:0]   nempty;
  logic [2*NUM_CH-1:0] ne_dbl;
  logic [NUM_CH-1:0]   ne_rot;
  logic [CH_W-1:0]     pick_off;
  logic [CH_W:0]       pick_sum;
  logic [CH_W-1:0]     pick_ch;
  logic                pick_vld;
  req_t                head;

  // Scheduler state and registered outputs
  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  req_t              out_q, out_d;
  logic [NUM_CH-1:0] done_q, done_d;

`ifdef ROUTER_REQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;
`endif

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (c == CH_W'(NUM_CH - 1)) ? '0 : c + CH_W'(1);
  endfunction

  // Unpack the per-channel request fields
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ent[i].src_addr = ch_src_addr[i*ADDR_W +: ADDR_W];
      wr_ent[i].dst_addr = ch_dst_addr[i*ADDR_W +: ADDR_W];
      wr_ent[i].src_dfx  = ch_src_dfx[i*DFX_W +: DFX_W];
      wr_ent[i].dst_dfx  = ch_dst_dfx[i*DFX_W +: DFX_W];
    end
  end

  // Round-robin pick: rotate the non-empty mask so the RR pointer lands on
  // bit 0, take the lowest set bit, then rotate the offset back.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      nempty[i] = (cnt_q[i] != '0);
    end
    ne_dbl   = {nempty, nempty} >> rr_q;
    ne_rot   = ne_dbl[NUM_CH-1:0];
    pick_vld = |ne_rot;
    pick_off = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ne_rot[k]) pick_off = CH_W'(k);
    end
    pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
    if (pick_sum >= (CH_W+1)'(NUM_CH)) pick_sum = pick_sum - (CH_W+1)'(NUM_CH);
    pick_ch = pick_sum[CH_W-1:0];
    head    = fifo_mem[pick_ch][rd_ptr_q[pick_ch]];
  end

  // FIFO pointer/count update. The head leaves the FIFO when it is issued,
  // so a push and a pop on one channel in the same cycle cancel in the count.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      push[i]     = ch_req_valid[i] & ready_q[i];
      pop[i]      = (state_q == IDLE) && pick_vld && (pick_ch == CH_W'(i));
      wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PTR_W'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PTR_W'(1) : rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      ready_d[i] = (cnt_d[i] != CNT_W'(FIFO_DEPTH));
    end
  end

  // Scheduler next-state. IDLE is always visited between requests, which
  // guarantees at least one low cycle on router_start_req.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    out_d   = out_q;
    done_d  = '0;
`ifdef ROUTER_REQ_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    to_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          out_d   = head;
          grant_d = pick_ch;
          state_d = REQ;
`ifdef ROUTER_REQ_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      REQ: begin
        // Ack is tested first so an ack on the last allowed cycle completes
        // normally instead of timing out.
        if (rtr.router_ack) begin
          done_d[grant_q] = 1'b1;
          rr_d            = next_ch(grant_q);
          state_d         = IDLE;
        end
`ifdef ROUTER_REQ_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          to_err_d = 1'b1;
          rr_d     = next_ch(grant_q);
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage carries data only and needs no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) fifo_mem[i][wr_ptr_q[i]] <= wr_ent[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      out_q   <= '0;
      done_q  <= '0;
      ready_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
`ifdef ROUTER_REQ_TIMEOUT_EN
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      out_q   <= out_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
`ifdef ROUTER_REQ_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
`endif
    end
  end

  assign rtr.router_start_req = (state_q == REQ);
  assign rtr.router_scr_addr  = out_q.src_addr;
  assign rtr.router_dst_addr  = out_q.dst_addr;
  assign rtr.router_src_dfx   = out_q.src_dfx;
  assign rtr.router_dst_dfx   = out_q.dst_dfx;
  assign busy                 = (state_q == REQ);
  assign grant_ch             = grant_q;
  assign ch_done              = done_q;
  assign ch_req_ready         = ready_q;
`ifdef ROUTER_REQ_TIMEOUT_EN
  assign timeout_err = to_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_req_sched.sv
module tb_router_req_sched;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 10;
  localparam int DFX_W  = 2;
  localparam int DEPTH  = 4;
  localparam int TO_CYC = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     ack = 1'b0;
  logic [NUM_CH-1:0]        ch_req_valid = '0;
  logic [NUM_CH-1:0]        ch_req_ready;
  logic [NUM_CH*ADDR_W-1:0] ch_src_addr = '0;
  logic [NUM_CH*ADDR_W-1:0] ch_dst_addr = '0;
  logic [NUM_CH*DFX_W-1:0]  ch_src_dfx = '0;
  logic [NUM_CH*DFX_W-1:0]  ch_dst_dfx = '0;
  logic [1:0]               grant_ch;
  logic                     busy;
  logic [NUM_CH-1:0]        ch_done;
  logic                     timeout_err;

  router_req_sched_if #(.ADDR_W(ADDR_W), .DFX_W(DFX_W)) rtr ();
  assign rtr.router_ack = ack;

  router_req_sched #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DFX_W(DFX_W),
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
    .ch_src_addr(ch_src_addr), .ch_dst_addr(ch_dst_addr),
    .ch_src_dfx(ch_src_dfx), .ch_dst_dfx(ch_dst_dfx),
    .rtr(rtr),
    .grant_ch(grant_ch), .busy(busy), .ch_done(ch_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [DFX_W-1:0]  sd;
    logic [DFX_W-1:0]  dd;
  } req_t;

  req_t              mq [NUM_CH][$];
  logic              m_busy;
  logic [1:0]        m_grant;
  req_t              m_cur;
  logic [NUM_CH-1:0] m_done;
  logic [NUM_CH-1:0] m_ready;
  logic              m_to;
  int                m_rr;
  int                m_timer;

  always @(posedge clk or negedge rst_n) begin : model
    logic [NUM_CH-1:0] acc;
    logic [NUM_CH-1:0] rdy;
    int                pc;
    bit                found;
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      m_busy  <= 1'b0;
      m_grant <= '0;
      m_cur   <= '0;
      m_done  <= '0;
      m_ready <= '0;
      m_to    <= 1'b0;
      m_rr    <= 0;
      m_timer <= 0;
    end else begin
      acc    = ch_req_valid & m_ready;
      m_done <= '0;
      m_to   <= 1'b0;
      if (!m_busy) begin
        // Pick uses queue contents from before this edge's pushes
        found = 1'b0;
        pc    = 0;
        for (int k = 0; k < NUM_CH; k++) begin
          if (!found && mq[(m_rr + k) % NUM_CH].size() > 0) begin
            found = 1'b1;
            pc    = (m_rr + k) % NUM_CH;
          end
        end
        if (found) begin
          m_cur   <= mq[pc].pop_front();
          m_grant <= 2'(pc);
          m_busy  <= 1'b1;
          m_timer <= 0;
        end
      end else if (ack) begin
        m_busy <= 1'b0;
        m_done <= NUM_CH'(1) << m_grant;
        m_rr   <= (int'(m_grant) + 1) % NUM_CH;
      end
`ifdef ROUTER_REQ_TIMEOUT_EN
      else if (m_timer + 1 == TO_CYC) begin
        m_busy <= 1'b0;
        m_to   <= 1'b1;
        m_rr   <= (int'(m_grant) + 1) % NUM_CH;
      end else begin
        m_timer <= m_timer + 1;
      end
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        if (acc[i]) mq[i].push_back({ch_src_addr[i*ADDR_W +: ADDR_W], ch_dst_addr[i*ADDR_W +: ADDR_W],
                                     ch_src_dfx[i*DFX_W +: DFX_W], ch_dst_dfx[i*DFX_W +: DFX_W]});
        rdy[i] = (mq[i].size() < DEPTH);
      end
      m_ready <= rdy;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("start_req", 32'(rtr.router_start_req), 32'(m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("ready", 32'(ch_req_ready), 32'(m_ready));
      chk("ch_done", 32'(ch_done), 32'(m_done));
      chk("timeout_err", 32'(timeout_err), 32'(m_to));
      if (m_busy) begin
        chk("grant_ch", 32'(grant_ch), 32'(m_grant));
        chk("src_addr", 32'(rtr.router_scr_addr), 32'(m_cur.src));
        chk("dst_addr", 32'(rtr.router_dst_addr), 32'(m_cur.dst));
        chk("src_dfx", 32'(rtr.router_src_dfx), 32'(m_cur.sd));
        chk("dst_dfx", 32'(rtr.router_dst_dfx), 32'(m_cur.dd));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ch_req_valid = '0;
    ack = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic set_ch(input int c, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                        input logic [DFX_W-1:0] sd, input logic [DFX_W-1:0] dd);
    ch_src_addr[c*ADDR_W +: ADDR_W] = s;
    ch_dst_addr[c*ADDR_W +: ADDR_W] = d;
    ch_src_dfx[c*DFX_W +: DFX_W]    = sd;
    ch_dst_dfx[c*DFX_W +: DFX_W]    = dd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int g[$];
    int s[$];
    bit pb;
    bit accepted;
    int hi0;
    int pulses;
    bit saw1;

    cmp_en = 1'b1;
    tick(1);
    chk("reset start_req", 32'(rtr.router_start_req), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset grant", 32'(grant_ch), 32'd0);
    do_reset();
    chk("ready after reset", 32'(ch_req_ready), 32'hf);

    // Test 1: single request on ch1
    set_ch(1, 10'h001, 10'h005, 2'b01, 2'b10);
    ch_req_valid = 4'b0010;
    tick(1);
    ch_req_valid = '0;
    chk("t1 not yet started", 32'(rtr.router_start_req), 32'd0);
    tick(1);
    chk("t1 start_req", 32'(rtr.router_start_req), 32'd1);
    chk("t1 src", 32'(rtr.router_scr_addr), 32'h001);
    chk("t1 dst", 32'(rtr.router_dst_addr), 32'h005);
    chk("t1 sdfx", 32'(rtr.router_src_dfx), 32'd1);
    chk("t1 ddfx", 32'(rtr.router_dst_dfx), 32'd2);
    chk("t1 grant", 32'(grant_ch), 32'd1);
    tick(2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t1 done pulse", 32'(ch_done), 32'h2);
    chk("t1 start dropped", 32'(rtr.router_start_req), 32'd0);
    tick(1);
    chk("t1 done once", 32'(ch_done), 32'h0);

    // Test 2: round-robin order with ack held high
    do_reset();
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 10'(16 + c), 10'(32 + c), 2'(c), 2'(3 - c));
    ch_req_valid = 4'hf;
    tick(1);
    ch_req_valid = '0;
    ack = 1'b1;
    pb = 1'b0;
    for (int cyc = 0; cyc < 40 && g.size() < 4; cyc++) begin
      if (busy && !pb) g.push_back(int'(grant_ch));
      pb = busy;
      tick(1);
    end
    ch_req_valid = 4'b0101;
    tick(1);
    ch_req_valid = '0;
    for (int cyc = 0; cyc < 40 && g.size() < 6; cyc++) begin
      if (busy && !pb) g.push_back(int'(grant_ch));
      pb = busy;
      tick(1);
    end
    ack = 1'b0;
    chk("t2 grant count", 32'(g.size()), 32'd6);
    if (g.size() == 6) begin
      chk("t2 grant0", 32'(g[0]), 32'd0);
      chk("t2 grant1", 32'(g[1]), 32'd1);
      chk("t2 grant2", 32'(g[2]), 32'd2);
      chk("t2 grant3", 32'(g[3]), 32'd3);
      chk("t2 grant4", 32'(g[4]), 32'd0);
      chk("t2 grant5", 32'(g[5]), 32'd2);
    end

    // Test 3: ch3 overfill; in-flight request plus DEPTH queued
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_ch(3, 10'(256 + k), 10'(512 + k), 2'(k), 2'(3 - k));
      ch_req_valid = 4'b1000;
      chk($sformatf("t3 ready before push %0d", k), 32'(ch_req_ready[3]), (k == 5) ? 32'd0 : 32'd1);
      if (k < 5) tick(1);
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    accepted = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (ch_req_ready[3]) begin
        accepted = 1'b1;
        tick(1);
        break;
      end
      tick(1);
    end
    ch_req_valid = '0;
    chk("t3 sixth accepted", 32'(accepted), 32'd1);
    ack = 1'b1;
    pb = 1'b0;
    for (int cyc = 0; cyc < 40 && s.size() < 5; cyc++) begin
      if (busy && !pb) s.push_back(int'(rtr.router_scr_addr));
      pb = busy;
      tick(1);
    end
    ack = 1'b0;
    chk("t3 drained count", 32'(s.size()), 32'd5);
    for (int k = 0; k < s.size(); k++) chk($sformatf("t3 order %0d", k), 32'(s[k]), 32'(257 + k));

    // Test 4: reset while busy
    do_reset();
    set_ch(1, 10'h0aa, 10'h055, 2'b11, 2'b00);
    set_ch(2, 10'h0bb, 10'h066, 2'b10, 2'b01);
    ch_req_valid = 4'b0110;
    tick(1);
    ch_req_valid = '0;
    tick(1);
    chk("t4 busy before reset", 32'(busy), 32'd1);
    chk("t4 grant before reset", 32'(grant_ch), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4 start_req cleared", 32'(rtr.router_start_req), 32'd0);
    chk("t4 busy cleared", 32'(busy), 32'd0);
    chk("t4 grant cleared", 32'(grant_ch), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("t4 idle after release", 32'(busy), 32'd0);
    chk("t4 ready all ones", 32'(ch_req_ready), 32'hf);

    // Test 5: timeout behaviour
    do_reset();
    set_ch(0, 10'h111, 10'h222, 2'b01, 2'b01);
    set_ch(1, 10'h333, 10'h044, 2'b10, 2'b10);
    ch_req_valid = 4'b0011;
    tick(1);
    ch_req_valid = '0;
`ifdef ROUTER_REQ_TIMEOUT_EN
    hi0 = 0;
    pulses = 0;
    saw1 = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (rtr.router_start_req && grant_ch == 2'd0) hi0++;
      if (timeout_err) pulses++;
      if (rtr.router_start_req && grant_ch == 2'd1) saw1 = 1'b1;
      tick(1);
    end
    chk("t5 start high cycles", 32'(hi0), 32'(TO_CYC));
    chk("t5 timeout pulses", 32'(pulses), 32'd1);
    chk("t5 next channel issued", 32'(saw1), 32'd1);
`else
    hi0 = 0;
    pulses = 0;
    saw1 = 1'b0;
    tick(101);
    chk("t5 still requesting", 32'(rtr.router_start_req), 32'd1);
    chk("t5 grant held", 32'(grant_ch), 32'd0);
    chk("t5 no timeout", 32'(timeout_err), 32'd0);
`endif

    // Test 6: ack in IDLE is ignored
    do_reset();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t6 no done", 32'(ch_done), 32'd0);
    chk("t6 still idle", 32'(busy), 32'd0);
    tick(1);
    chk("t6 no done later", 32'(ch_done), 32'd0);
    chk("t6 no start", 32'(rtr.router_start_req), 32'd0);

    tick(2);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
